// File: rtl/celda_tipica.sv
// ---------------------------------------------------------------------------
// celda_tipica
//   One cell of an MSB-first iterative comparator chain. The cell compares
//   its unsigned digit pair A/B under the mode {z,y}. The result only counts
//   when every more-significant digit was equal (g_in=1). Both outputs are
//   registered, so a long chain pipelines one stage per cell.
//
// Ports
//   clk     in   1   system clock, rising edge
//   rst_n   in   1   asynchronous active-low reset
//   z, y    in   1   mode select {z,y}: 00 gt, 01 lt, 10 eq, 11 ne
//   g_in    in   1   chain enable from the left cell (higher digits equal)
//   A, B    in   W   unsigned digit operands
//   f_mid   out  1   registered relation result for this cell
//   g_mid   out  1   registered chain enable for the right cell
// ---------------------------------------------------------------------------
module celda_tipica #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         z,
    input  logic         y,
    input  logic         g_in,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    output logic         f_mid,
    output logic         g_mid
);

    logic eq;
    logic gt;
    logic lt;
    logic rel;

    always_comb begin
        eq  = (A == B);
        gt  = (A > B);
        lt  = (A < B);
        rel = 1'b0;
        case ({z, y})
            2'b00: rel = gt;
            2'b01: rel = lt;
            2'b10: rel = eq;
            2'b11: rel = ~eq;
            default: rel = 1'b0;
        endcase
    end

    // g_mid only propagates while this digit is also equal, so the chain
    // enable dies at the first differing digit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_mid <= 1'b0;
            g_mid <= 1'b0;
        end else begin
            f_mid <= g_in & rel;
            g_mid <= g_in & eq;
        end
    end

endmodule

// File: tb/tb_celda_tipica.sv
module tb_celda_tipica;

    logic       clk;
    logic       rst_n;
    logic       z;
    logic       y;
    logic       g_in;
    logic [2:0] a;
    logic [2:0] b;
    logic       f_mid;
    logic       g_mid;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic exp_f;
    logic exp_g;

    celda_tipica #(.W(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .z     (z),
        .y     (y),
        .g_in  (g_in),
        .A     (a),
        .B     (b),
        .f_mid (f_mid),
        .g_mid (g_mid)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Reference: relation by plain integer arithmetic on the mode number.
    function automatic logic model_f(input int av, input int bv, input int mode, input int g);
        logic r;
        if (mode == 0)      r = (av > bv);
        else if (mode == 1) r = (av < bv);
        else if (mode == 2) r = (av == bv);
        else                r = (av != bv);
        return (g != 0) && r;
    endfunction

    function automatic logic model_g(input int av, input int bv, input int g);
        return (g != 0) && (av == bv);
    endfunction

    // Drives a vector and records the expected outputs for the next edge.
    task automatic drive(input int av, input int bv, input int mode, input int g);
        a     = av[2:0];
        b     = bv[2:0];
        z     = mode[1];
        y     = mode[0];
        g_in  = g[0];
        exp_f = model_f(av, bv, mode, g);
        exp_g = model_g(av, bv, g);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(7, 7, 2, 1);
        repeat (3) @(posedge clk);
        #1;
        total_cnt++;
        if (f_mid !== 1'b0) $display("FAIL reset_f: got %b expected 0", f_mid);
        else pass_cnt++;
        total_cnt++;
        if (g_mid !== 1'b0) $display("FAIL reset_g: got %b expected 0", g_mid);
        else pass_cnt++;
        rst_n = 1'b1;
        // Outputs become 1/1 after an edge; then assert reset with no edge.
        @(posedge clk);
        #1;
        total_cnt++;
        if ({f_mid, g_mid} !== 2'b11) $display("FAIL reset_pre: got %b%b expected 11", f_mid, g_mid);
        else pass_cnt++;
        #3 rst_n = 1'b0;
        #1;
        total_cnt++;
        if ({f_mid, g_mid} !== 2'b00) $display("FAIL reset_async: got %b%b expected 00", f_mid, g_mid);
        else pass_cnt++;
        #2 rst_n = 1'b1;
    endtask

    task automatic test_directed();
        int vec [5][5] = '{
            '{0, 0, 2, 0, 0},
            '{1, 2, 1, 1, 0},
            '{6, 3, 3, 0, 0},
            '{7, 5, 0, 1, 0},
            '{5, 5, 2, 1, 0}
        };
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #2 drive(vec[i][0], vec[i][1], vec[i][2], vec[i][3]);
            @(posedge clk);
            #1;
            total_cnt++;
            if (f_mid !== exp_f) $display("FAIL directed%0d_f: got %b expected %b", i, f_mid, exp_f);
            else pass_cnt++;
            total_cnt++;
            if (g_mid !== exp_g) $display("FAIL directed%0d_g: got %b expected %b", i, g_mid, exp_g);
            else pass_cnt++;
        end
    endtask

    task automatic test_boundaries();
        int pairs [3][2] = '{'{0, 0}, '{7, 7}, '{7, 0}};
        for (int p = 0; p < 3; p++) begin
            for (int m = 0; m < 4; m++) begin
                @(posedge clk);
                #2 drive(pairs[p][0], pairs[p][1], m, 1);
                @(posedge clk);
                #1;
                total_cnt++;
                if ({f_mid, g_mid} !== {exp_f, exp_g})
                    $display("FAIL boundary_a%0d_b%0d_m%0d: got %b%b expected %b%b",
                             pairs[p][0], pairs[p][1], m, f_mid, g_mid, exp_f, exp_g);
                else pass_cnt++;
            end
        end
    endtask

    // Back-to-back: a new random vector every cycle, mode included.
    task automatic test_back_to_back();
        logic pf;
        logic pg;
        @(posedge clk);
        #2 drive($urandom_range(7), $urandom_range(7), $urandom_range(3), $urandom_range(1));
        for (int i = 0; i < 300; i++) begin
            pf = exp_f;
            pg = exp_g;
            @(posedge clk);
            #1;
            total_cnt++;
            if ({f_mid, g_mid} !== {pf, pg})
                $display("FAIL random%0d: got %b%b expected %b%b", i, f_mid, g_mid, pf, pg);
            else pass_cnt++;
            #1 drive($urandom_range(7), $urandom_range(7), $urandom_range(3),
                     ($urandom_range(3) != 0) ? 1 : 0);
        end
    endtask

    task automatic test_reset_midstream();
        @(posedge clk);
        #2 drive(7, 5, 0, 1);
        @(posedge clk);
        #1;
        total_cnt++;
        if ({f_mid, g_mid} !== 2'b10) $display("FAIL mid_before: got %b%b expected 10", f_mid, g_mid);
        else pass_cnt++;
        #4 rst_n = 1'b0;
        #1;
        total_cnt++;
        if ({f_mid, g_mid} !== 2'b00) $display("FAIL mid_async: got %b%b expected 00", f_mid, g_mid);
        else pass_cnt++;
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        total_cnt++;
        if ({f_mid, g_mid} !== 2'b10) $display("FAIL mid_release: got %b%b expected 10", f_mid, g_mid);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_boundaries();
        test_back_to_back();
        test_reset_midstream();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
